// File: rtl/draw_particle2.sv
// rtl/draw_particle2.sv - 64x64 sprite compositor with frame-latched position and 3-clock pipeline
module draw_particle2 #(
  parameter logic [11:0] TRANSPARENT = 12'hF0F,
  parameter int          SPRITE_SIZE = 64
) (
  input  logic        clk60MHz,
  input  logic        rst_n,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        visible,
  input  logic [11:0] rgb_pixel,
  output logic [11:0] pixel_addr,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  // Inclusive extent of the sprite beyond its top-left corner.
  localparam logic [12:0] EXTENT = 13'(SPRITE_SIZE - 1);

  logic        vblnk_prev;
  logic [11:0] xs;
  logic [11:0] ys;
  logic        vis;

  // Stage-1 registers
  logic [10:0] s1_hcount;
  logic [10:0] s1_vcount;
  logic        s1_hsync;
  logic        s1_vsync;
  logic        s1_hblnk;
  logic        s1_vblnk;
  logic [11:0] s1_rgb;
  logic        s1_in_box;

  // Stage-2 registers, aligned with rgb_pixel from the ROM
  logic [10:0] s2_hcount;
  logic [10:0] s2_vcount;
  logic        s2_hsync;
  logic        s2_vsync;
  logic        s2_hblnk;
  logic        s2_vblnk;
  logic [11:0] s2_rgb;
  logic        s2_in_box;

  logic [12:0] h_ext;
  logic [12:0] v_ext;
  logic [12:0] x_ext;
  logic [12:0] y_ext;
  logic        in_box;
  logic [5:0]  col;
  logic [5:0]  row;

  // Box test widened to 13 bits so a corner near 4095 never wraps around to column/row 0.
  always_comb begin
    h_ext  = {2'b00, hcount_in};
    v_ext  = {2'b00, vcount_in};
    x_ext  = {1'b0, xs};
    y_ext  = {1'b0, ys};
    in_box = vis &&
             (h_ext >= x_ext) && (h_ext <= x_ext + EXTENT) &&
             (v_ext >= y_ext) && (v_ext <= y_ext + EXTENT);
    // Low 6 bits of a difference depend only on the low 6 bits of the operands.
    col    = hcount_in[5:0] - xs[5:0];
    row    = vcount_in[5:0] - ys[5:0];
  end

  // Shadow position/enable, loaded only on the vblnk rising edge so a frame never tears.
  always_ff @(posedge clk60MHz or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_prev <= 1'b0;
      xs         <= '0;
      ys         <= '0;
      vis        <= 1'b0;
    end else begin
      vblnk_prev <= vblnk_in;
      if (vblnk_in && !vblnk_prev) begin
        xs  <= xpos;
        ys  <= ypos;
        vis <= visible;
      end
    end
  end

  // Stage 1: register timing and background, compute box hit and ROM address.
  always_ff @(posedge clk60MHz or negedge rst_n) begin
    if (!rst_n) begin
      s1_hcount  <= '0;
      s1_vcount  <= '0;
      s1_hsync   <= 1'b0;
      s1_vsync   <= 1'b0;
      s1_hblnk   <= 1'b0;
      s1_vblnk   <= 1'b0;
      s1_rgb     <= '0;
      s1_in_box  <= 1'b0;
      pixel_addr <= '0;
    end else begin
      s1_hcount  <= hcount_in;
      s1_vcount  <= vcount_in;
      s1_hsync   <= hsync_in;
      s1_vsync   <= vsync_in;
      s1_hblnk   <= hblnk_in;
      s1_vblnk   <= vblnk_in;
      s1_rgb     <= rgb_in;
      s1_in_box  <= in_box;
      pixel_addr <= in_box ? {row, col} : 12'h000;
    end
  end

  // Stage 2: delay by one more clock while the ROM produces rgb_pixel.
  always_ff @(posedge clk60MHz or negedge rst_n) begin
    if (!rst_n) begin
      s2_hcount <= '0;
      s2_vcount <= '0;
      s2_hsync  <= 1'b0;
      s2_vsync  <= 1'b0;
      s2_hblnk  <= 1'b0;
      s2_vblnk  <= 1'b0;
      s2_rgb    <= '0;
      s2_in_box <= 1'b0;
    end else begin
      s2_hcount <= s1_hcount;
      s2_vcount <= s1_vcount;
      s2_hsync  <= s1_hsync;
      s2_vsync  <= s1_vsync;
      s2_hblnk  <= s1_hblnk;
      s2_vblnk  <= s1_vblnk;
      s2_rgb    <= s1_rgb;
      s2_in_box <= s1_in_box;
    end
  end

  // Stage 3: composite sprite over background, black during blanking.
  always_ff @(posedge clk60MHz or negedge rst_n) begin
    if (!rst_n) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= s2_hcount;
      vcount_out <= s2_vcount;
      hsync_out  <= s2_hsync;
      vsync_out  <= s2_vsync;
      hblnk_out  <= s2_hblnk;
      vblnk_out  <= s2_vblnk;
      if (s2_hblnk || s2_vblnk)
        rgb_out <= 12'h000;
      else if (s2_in_box && (rgb_pixel != TRANSPARENT))
        rgb_out <= rgb_pixel;
      else
        rgb_out <= s2_rgb;
    end
  end

endmodule

// File: tb/tb_draw_particle2.sv
// tb/tb_draw_particle2.sv - directed vector bench for draw_particle2
module tb_draw_particle2;

  logic        clk60MHz = 1'b0;
  logic        rst_n;
  logic [10:0] hcount_in;
  logic [10:0] vcount_in;
  logic        hsync_in;
  logic        vsync_in;
  logic        hblnk_in;
  logic        vblnk_in;
  logic [11:0] rgb_in;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        visible;
  logic [11:0] rgb_pixel;
  logic [11:0] pixel_addr;
  logic [10:0] hcount_out;
  logic [10:0] vcount_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        hblnk_out;
  logic        vblnk_out;
  logic [11:0] rgb_out;

  int errors = 0;
  int checks = 0;

  draw_particle2 dut (
    .clk60MHz  (clk60MHz),
    .rst_n     (rst_n),
    .hcount_in (hcount_in),
    .vcount_in (vcount_in),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .hblnk_in  (hblnk_in),
    .vblnk_in  (vblnk_in),
    .rgb_in    (rgb_in),
    .xpos      (xpos),
    .ypos      (ypos),
    .visible   (visible),
    .rgb_pixel (rgb_pixel),
    .pixel_addr(pixel_addr),
    .hcount_out(hcount_out),
    .vcount_out(vcount_out),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .hblnk_out (hblnk_out),
    .vblnk_out (vblnk_out),
    .rgb_out   (rgb_out)
  );

  always #8 clk60MHz = ~clk60MHz;

  // Synchronous sprite ROM: 000 transparent, 14A green, everything else addr^800.
  function automatic logic [11:0] rom(input logic [11:0] a);
    if (a == 12'h000) return 12'hF0F;
    if (a == 12'h14A) return 12'h0F0;
    return a ^ 12'h800;
  endfunction

  always @(posedge clk60MHz) rgb_pixel <= rom(pixel_addr);

  typedef struct {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
    logic [11:0] exp_addr;
    logic [11:0] exp_rgb;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic hs,
                       input logic vs, input logic hb, input logic vb, input logic [11:0] rgb);
    hcount_in = h; vcount_in = v; hsync_in = hs; vsync_in = vs;
    hblnk_in = hb; vblnk_in = vb; rgb_in = rgb;
  endtask

  // Produce a vblnk rising edge so the shadow registers take xpos/ypos/visible.
  task automatic latch(input logic [11:0] x, input logic [11:0] y, input logic v);
    @(negedge clk60MHz);
    xpos = x; ypos = y; visible = v;
    drive(11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    @(negedge clk60MHz);
    vblnk_in = 1'b1;
    @(negedge clk60MHz);
    vblnk_in = 1'b0;
  endtask

  // Hold one vector steady: address checked one clock later, outputs three clocks later.
  task automatic run_vec(input string name, input vec_t t);
    @(negedge clk60MHz);
    drive(t.h, t.v, t.hs, t.vs, t.hb, t.vb, t.rgb);
    @(negedge clk60MHz);
    chk({name, "_addr"}, 32'(pixel_addr), 32'(t.exp_addr));
    @(negedge clk60MHz);
    @(negedge clk60MHz);
    chk({name, "_rgb"}, 32'(rgb_out), 32'(t.exp_rgb));
    chk({name, "_timing"}, {6'd0, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out},
        {6'd0, t.h, t.v, t.hs, t.vs, t.hb, t.vb});
  endtask

  vec_t tbl[9];
  vec_t one;

  logic [10:0] sh[10];
  logic        shs[10];
  logic        shb[10];
  logic [11:0] srgb[10];

  initial begin
    // sprite at (200,100): in-box, transparent corner, edges, far corner, blanking, syncs
    tbl[0] = '{11'd210, 11'd105, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123, 12'h14A, 12'h0F0};
    tbl[1] = '{11'd200, 11'd100, 1'b0, 1'b0, 1'b0, 1'b0, 12'h456, 12'h000, 12'h456};
    tbl[2] = '{11'd199, 11'd100, 1'b0, 1'b0, 1'b0, 1'b0, 12'h789, 12'h000, 12'h789};
    tbl[3] = '{11'd264, 11'd100, 1'b0, 1'b0, 1'b0, 1'b0, 12'hABC, 12'h000, 12'hABC};
    tbl[4] = '{11'd263, 11'd163, 1'b0, 1'b0, 1'b0, 1'b0, 12'h111, 12'hFFF, 12'h7FF};
    tbl[5] = '{11'd263, 11'd164, 1'b0, 1'b0, 1'b0, 1'b0, 12'h222, 12'h000, 12'h222};
    tbl[6] = '{11'd210, 11'd105, 1'b0, 1'b0, 1'b1, 1'b0, 12'h333, 12'h14A, 12'h000};
    tbl[7] = '{11'd210, 11'd99,  1'b1, 1'b1, 1'b0, 1'b0, 12'h444, 12'h000, 12'h444};
    tbl[8] = '{11'd210, 11'd105, 1'b0, 1'b0, 1'b0, 1'b1, 12'h555, 12'h14A, 12'h000};

    rst_n = 1'b0;
    xpos = 12'd200; ypos = 12'd100; visible = 1'b1;
    drive(11'd210, 11'd105, 1'b1, 1'b1, 1'b1, 1'b0, 12'hABC);
    repeat (3) @(negedge clk60MHz);
    chk("reset_rgb", 32'(rgb_out), 32'h0);
    chk("reset_addr", 32'(pixel_addr), 32'h0);
    chk("reset_timing", {6'd0, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}, 32'h0);
    rst_n = 1'b1;

    // no sprite before the first vblnk edge even though visible=1
    one = '{11'd210, 11'd105, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0AA, 12'h000, 12'h0AA};
    run_vec("pre_vblnk", one);

    // exact 3-clock latency with a different value on every clock, sprite disabled
    latch(12'd0, 12'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      sh[i] = 11'(100 + i); shs[i] = (i == 2); shb[i] = (i == 5); srgb[i] = 12'(12'h100 + i);
    end
    for (int i = 0; i < 13; i++) begin
      @(negedge clk60MHz);
      if (i >= 3) begin
        chk("lat_h", 32'(hcount_out), 32'(sh[i-3]));
        chk("lat_sync", {30'd0, hsync_out, hblnk_out}, {30'd0, shs[i-3], shb[i-3]});
        chk("lat_rgb", 32'(rgb_out), shb[i-3] ? 32'h0 : 32'(srgb[i-3]));
      end
      if (i < 10) drive(sh[i], 11'd50, shs[i], 1'b0, shb[i], 1'b0, srgb[i]);
    end

    latch(12'd200, 12'd100, 1'b1);
    for (int i = 0; i < 9; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    // frame latching: new xpos ignored until next vblnk edge
    xpos = 12'd300;
    one = '{11'd210, 11'd105, 1'b0, 1'b0, 1'b0, 1'b0, 12'h321, 12'h14A, 12'h0F0};
    run_vec("old_frame_in", one);
    one = '{11'd310, 11'd105, 1'b0, 1'b0, 1'b0, 1'b0, 12'h321, 12'h000, 12'h321};
    run_vec("old_frame_out", one);
    latch(12'd300, 12'd100, 1'b1);
    one = '{11'd310, 11'd105, 1'b0, 1'b0, 1'b0, 1'b0, 12'h321, 12'h14A, 12'h0F0};
    run_vec("new_frame_in", one);
    one = '{11'd210, 11'd105, 1'b0, 1'b0, 1'b0, 1'b0, 12'h321, 12'h000, 12'h321};
    run_vec("new_frame_old", one);

    // right-edge clipping: columns 1000..1023 drawn, no wrap to column 0
    latch(12'd1000, 12'd100, 1'b1);
    one = '{11'd1023, 11'd100, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0CC, 12'h017, 12'h817};
    run_vec("clip_1023", one);
    one = '{11'd0, 11'd100, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0CC, 12'h000, 12'h0CC};
    run_vec("clip_0", one);
    one = '{11'd1005, 11'd101, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0CC, 12'h045, 12'h845};
    run_vec("clip_1005", one);

    // corner near 4095 must not wrap in the 13-bit compare
    latch(12'd4090, 12'd4090, 1'b1);
    one = '{11'd2, 11'd2, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0DD, 12'h000, 12'h0DD};
    run_vec("wrap_guard", one);

    // reset mid-draw clears at once, sprite absent until next vblnk edge
    latch(12'd200, 12'd100, 1'b1);
    one = '{11'd210, 11'd105, 1'b0, 1'b0, 1'b0, 1'b0, 12'h5A5, 12'h14A, 12'h0F0};
    run_vec("pre_reset", one);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_rgb", 32'(rgb_out), 32'h0);
    chk("mid_reset_addr", 32'(pixel_addr), 32'h0);
    chk("mid_reset_h", 32'(hcount_out), 32'h0);
    @(negedge clk60MHz);
    rst_n = 1'b1;
    one = '{11'd210, 11'd105, 1'b0, 1'b0, 1'b0, 1'b0, 12'h5A5, 12'h000, 12'h5A5};
    run_vec("post_reset", one);
    latch(12'd200, 12'd100, 1'b1);
    one = '{11'd210, 11'd105, 1'b0, 1'b0, 1'b0, 1'b0, 12'h5A5, 12'h14A, 12'h0F0};
    run_vec("post_reset_latch", one);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/draw_particle2.md
DRAW_PARTICLE2 -- requirements
Module: draw_particle2

Interface
REQ-001 Parameter: TRANSPARENT, default 12'hF0F, sprite colour treated as see-through.
REQ-002 Parameter: SPRITE_SIZE, default 64, sprite edge length in pixels; fixed at 64 (6-bit row/column index).
REQ-003 Port: clk60MHz  input  1  pixel clock; all registers on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: hcount_in, vcount_in  input  11 each  current pixel column/row from timing chain.
REQ-006 Port: hsync_in, vsync_in, hblnk_in, vblnk_in  input  1 each  timing strobes.
REQ-007 Port: rgb_in  input  12  background pixel from previous draw stage.
REQ-008 Port: xpos, ypos  input  12 each  requested sprite top-left corner, screen coordinates.
REQ-009 Port: visible  input  1  requested sprite enable.
REQ-010 Port: rgb_pixel  input  12  sprite ROM data; valid one clock after pixel_addr.
REQ-011 Port: pixel_addr  output  12  sprite ROM address {row[5:0], col[5:0]}.
REQ-012 Port: hcount_out, vcount_out  output  11 each  delayed counters.
REQ-013 Port: hsync_out, vsync_out, hblnk_out, vblnk_out  output  1 each  delayed strobes.
REQ-014 Port: rgb_out  output  12  composited pixel.

Function
REQ-015 Block SHALL hold shadow registers xs, ys, vis, loaded from xpos, ypos, visible only on the cycle where vblnk_in is 1 and its previous-cycle registered value is 0 (frame-start edge).
REQ-016 xpos/ypos/visible changes at any other time SHALL NOT affect the current frame.
REQ-017 Stage 1 SHALL register: in_box = vis AND xs <= hcount_in <= xs+63 AND ys <= vcount_in <= ys+63, comparisons in 13-bit unsigned arithmetic (no wrap at xs or ys near 4095).
REQ-018 Stage 1 SHALL register pixel_addr = {(vcount_in-ys)[5:0], (hcount_in-xs)[5:0]} when in box, else 12'h000.
REQ-019 Stage 1 SHALL register all timing inputs and rgb_in; stage 2 SHALL register stage-1 timing, rgb and in_box, aligning them with rgb_pixel.
REQ-020 Stage 3 (output) SHALL register timing from stage 2 and rgb_out per REQ-021..023.
REQ-021 If stage-2 hblnk or vblnk is 1: rgb_out SHALL be 12'h000.
REQ-022 Else if stage-2 in_box is 1 and rgb_pixel != TRANSPARENT: rgb_out SHALL be rgb_pixel.
REQ-023 Otherwise rgb_out SHALL be stage-2 rgb.
REQ-024 Total latency, any input to corresponding output, SHALL be exactly 3 clocks; hcount/vcount/sync/blank SHALL be bit-exact delayed copies.
REQ-025 Sprite partly off-screen (xs+63 > 1023 or ys+63 > 767) SHALL draw only on-screen pixels with correct addresses; no wrap to column/row 0.
REQ-026 Pipeline SHALL accept a new pixel every clock; no stalls, no handshake.

Reset
REQ-027 On rst_n=0, asynchronously: all outputs, pipeline registers, pixel_addr and xs/ys SHALL be 0; vis and vblnk edge register SHALL be 0.
REQ-028 After rst_n deassertion, no sprite SHALL appear until the first vblnk_in rising edge loads vis=1.
REQ-029 Reset asserted mid-line SHALL clear outputs within the same cycle; no partial pixels after release before new inputs propagate (3 clocks).

Verification
REQ-030 Latency: drive hcount_in=100, vcount_in=50, hsync_in pulse, visible=0 -> identical values on outputs exactly 3 clocks later, rgb_out = rgb_in.
REQ-031 Draw: xpos=200, ypos=100, visible=1 latched at vblnk edge; pixel (210,105) -> pixel_addr=12'h14A one clock later; ROM returns 12'h0F0 -> rgb_out=12'h0F0 at +3.
REQ-032 Transparency/edges: ROM returns 12'hF0F at (200,100) -> rgb_out=rgb_in; pixels (199,100) and (264,100) -> background, pixel_addr=0.
REQ-033 Frame latching: change xpos 200->300 mid-frame -> sprite stays at 200 until next vblnk_in rising edge, then at 300.
REQ-034 Blanking/clip: hblnk_in=1 within box -> rgb_out=0; xpos=1000 -> columns 1000..1023 drawn with col 0..23, none at hcount 0.
REQ-035 Reset: assert rst_n=0 while drawing -> all outputs 0 immediately; after release sprite absent until next vblnk edge.
